// File: rtl/tlb_unit_pkg.sv
// rtl/tlb_unit_pkg.sv - shared TLB geometry, command codes, entry layout and helpers
package tlb_unit_pkg;

    localparam int TLB_ENTRIES = 32;
    localparam int TLB_IDXBITS = 5;

    typedef enum logic [1:0] {
        OP_TLBR  = 2'd0,
        OP_TLBWI = 2'd1,
        OP_TLBWR = 2'd2,
        OP_TLBP  = 2'd3
    } cmd_op_e;

    // EntryLo / EntryHi field positions as seen by CP0
    localparam int LO_PFN_MSB  = 25;
    localparam int LO_PFN_LSB  = 6;
    localparam int LO_C_MSB    = 5;
    localparam int LO_C_LSB    = 3;
    localparam int LO_D        = 2;
    localparam int LO_V        = 1;
    localparam int LO_G        = 0;
    localparam int HI_VPN2_MSB = 31;
    localparam int HI_VPN2_LSB = 13;
    localparam int HI_ASID_MSB = 7;
    localparam int HI_ASID_LSB = 0;

    // Field order mirrors EntryLo[25:1] so a page can be sliced straight out of it
    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [11:0] mask;
        tlb_page_t   pg0;
        tlb_page_t   pg1;
    } tlb_entry_t;

    typedef struct packed {
        logic        hit;
        logic        v;
        logic        d;
        logic [2:0]  c;
        logic [31:0] paddr;
    } tlb_result_t;

    function automatic logic [3:0] mask_width(input logic [11:0] m);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 12; i++) begin
            n = n + {3'b0, m[i]};
        end
        return n;
    endfunction

    // Lowest set bit wins
    function automatic logic [TLB_IDXBITS-1:0] first_hit(input logic [TLB_ENTRIES-1:0] vec);
        logic [TLB_IDXBITS-1:0] idx;
        idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = TLB_IDXBITS'(i);
            end
        end
        return idx;
    endfunction

    function automatic tlb_result_t translate(input tlb_page_t pg0, input tlb_page_t pg1,
                                              input logic [11:0] mask, input logic hit,
                                              input logic odd, input logic [31:0] vaddr);
        tlb_result_t r;
        tlb_page_t   pg;
        r  = '0;
        pg = odd ? pg1 : pg0;
        if (hit) begin
            r.hit   = 1'b1;
            r.v     = pg.v;
            r.d     = pg.d;
            r.c     = pg.c;
            r.paddr = {(pg.pfn & ~{8'b0, mask}) | (vaddr[31:12] & {8'b0, mask}), vaddr[11:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - combinational VA/ASID compare against every TLB entry
module tlb_match
    import tlb_unit_pkg::*;
(
    input  logic [TLB_ENTRIES-1:0] present,
    input  tlb_entry_t             entries [TLB_ENTRIES],
    input  logic [31:0]            vaddr,
    input  logic [7:0]             asid,
    output logic [TLB_ENTRIES-1:0] hit_vec,
    output logic                   hit,
    output logic [TLB_IDXBITS-1:0] idx,
    output logic                   odd
);

    logic [4:0] sel;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            hit_vec[i] = present[i]
                && ((entries[i].vpn2 & ~{7'b0, entries[i].mask})
                    == (vaddr[31:13] & ~{7'b0, entries[i].mask}))
                && (entries[i].g || (entries[i].asid == asid));
        end
    end

    assign hit = |hit_vec;
    assign idx = first_hit(hit_vec);

    // The even/odd selector sits just above the widened page offset
    assign sel = 5'd12 + {1'b0, mask_width(entries[idx].mask)};
    assign odd = vaddr[sel];

endmodule

// File: rtl/tlb_unit.sv
// rtl/tlb_unit.sv - 32-entry joint TLB with CP0 command FSM and fetch/data lookup ports
module tlb_unit
    import tlb_unit_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    output logic        cmd_done,
    input  logic [31:0] index,
    input  logic [31:0] random,
    input  logic [31:0] entrylo0,
    input  logic [31:0] entrylo1,
    input  logic [11:0] mask,
    input  logic [31:0] entryhi,
    output logic        tlbr,
    output logic [31:0] tlbr_lo0,
    output logic [31:0] tlbr_lo1,
    output logic [31:0] tlbr_hi,
    output logic [11:0] tlbr_mask,
    output logic        tlbwr,
    output logic        tlbp,
    output logic [31:0] tlbp_index,
    input  logic        i_req,
    input  logic [31:0] i_vaddr,
    output logic        i_hit,
    output logic        i_v,
    output logic        i_d,
    output logic [2:0]  i_c,
    output logic [31:0] i_paddr,
    input  logic        d_req,
    input  logic [31:0] d_vaddr,
    output logic        d_hit,
    output logic        d_v,
    output logic        d_d,
    output logic [2:0]  d_c,
    output logic [31:0] d_paddr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e                 state;
    cmd_op_e                op;
    tlb_entry_t             entries [TLB_ENTRIES];
    logic [TLB_ENTRIES-1:0] present;
    logic [TLB_ENTRIES-1:0] probe_vec;
    logic [TLB_ENTRIES-1:0] probe_hold;
    logic                   accept;
    logic                   do_write;
    logic [TLB_IDXBITS-1:0] wr_idx;
    logic [TLB_IDXBITS-1:0] rd_idx;
    tlb_entry_t             new_entry;
    tlb_entry_t             rd_entry;

    logic                   i_hit_c, i_odd, d_hit_c, d_odd;
    logic [TLB_IDXBITS-1:0] i_idx, d_idx;
    tlb_result_t            i_res, d_res;

    logic [TLB_ENTRIES-1:0] unused_i_vec, unused_d_vec;
    logic                   unused_probe_hit, unused_probe_odd;
    logic [TLB_IDXBITS-1:0] unused_probe_idx;
    logic                   unused_bits;

    assign op        = cmd_op_e'(cmd_op);
    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign do_write  = accept && (op == OP_TLBWI || op == OP_TLBWR);
    assign tlbwr     = accept && (op == OP_TLBWR);
    assign wr_idx    = (op == OP_TLBWR) ? random[TLB_IDXBITS-1:0] : index[TLB_IDXBITS-1:0];
    assign rd_idx    = index[TLB_IDXBITS-1:0];
    assign rd_entry  = entries[rd_idx];

    always_comb begin
        new_entry      = '0;
        new_entry.vpn2 = entryhi[HI_VPN2_MSB:HI_VPN2_LSB];
        new_entry.asid = entryhi[HI_ASID_MSB:HI_ASID_LSB];
        new_entry.g    = entrylo0[LO_G] & entrylo1[LO_G];
        new_entry.mask = mask;
        new_entry.pg0  = tlb_page_t'(entrylo0[LO_PFN_MSB:LO_V]);
        new_entry.pg1  = tlb_page_t'(entrylo1[LO_PFN_MSB:LO_V]);
    end

    // Entry payload is deliberately not reset; only the present bits are
    always_ff @(posedge clk) begin
        if (resetn && do_write) begin
            entries[wr_idx] <= new_entry;
        end
    end

    tlb_match u_match_i (
        .present (present),
        .entries (entries),
        .vaddr   (i_vaddr),
        .asid    (entryhi[HI_ASID_MSB:HI_ASID_LSB]),
        .hit_vec (unused_i_vec),
        .hit     (i_hit_c),
        .idx     (i_idx),
        .odd     (i_odd)
    );

    tlb_match u_match_d (
        .present (present),
        .entries (entries),
        .vaddr   (d_vaddr),
        .asid    (entryhi[HI_ASID_MSB:HI_ASID_LSB]),
        .hit_vec (unused_d_vec),
        .hit     (d_hit_c),
        .idx     (d_idx),
        .odd     (d_odd)
    );

    tlb_match u_match_p (
        .present (present),
        .entries (entries),
        .vaddr   (entryhi),
        .asid    (entryhi[HI_ASID_MSB:HI_ASID_LSB]),
        .hit_vec (probe_vec),
        .hit     (unused_probe_hit),
        .idx     (unused_probe_idx),
        .odd     (unused_probe_odd)
    );

    // Lookups read storage before this edge's write lands, giving old-contents semantics
    always_ff @(posedge clk) begin
        if (!resetn) begin
            i_res <= '0;
            d_res <= '0;
        end else begin
            if (i_req) begin
                i_res <= translate(entries[i_idx].pg0, entries[i_idx].pg1,
                                   entries[i_idx].mask, i_hit_c, i_odd, i_vaddr);
            end
            if (d_req) begin
                d_res <= translate(entries[d_idx].pg0, entries[d_idx].pg1,
                                   entries[d_idx].mask, d_hit_c, d_odd, d_vaddr);
            end
        end
    end

    assign i_hit   = i_res.hit;
    assign i_v     = i_res.v;
    assign i_d     = i_res.d;
    assign i_c     = i_res.c;
    assign i_paddr = i_res.paddr;
    assign d_hit   = d_res.hit;
    assign d_v     = d_res.v;
    assign d_d     = d_res.d;
    assign d_c     = d_res.c;
    assign d_paddr = d_res.paddr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            present    <= '0;
            probe_hold <= '0;
            cmd_done   <= 1'b0;
            tlbr       <= 1'b0;
            tlbp       <= 1'b0;
            tlbr_lo0   <= '0;
            tlbr_lo1   <= '0;
            tlbr_hi    <= '0;
            tlbr_mask  <= '0;
            tlbp_index <= '0;
        end else begin
            cmd_done <= 1'b0;
            tlbr     <= 1'b0;
            tlbp     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (op)
                            OP_TLBR: begin
                                if (present[rd_idx]) begin
                                    tlbr_lo0  <= {6'b0, rd_entry.pg0, rd_entry.g};
                                    tlbr_lo1  <= {6'b0, rd_entry.pg1, rd_entry.g};
                                    tlbr_hi   <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
                                    tlbr_mask <= rd_entry.mask;
                                end else begin
                                    tlbr_lo0  <= '0;
                                    tlbr_lo1  <= '0;
                                    tlbr_hi   <= '0;
                                    tlbr_mask <= '0;
                                end
                                tlbr     <= 1'b1;
                                cmd_done <= 1'b1;
                                state    <= S_RESP;
                            end
                            OP_TLBWI, OP_TLBWR: begin
                                present[wr_idx] <= 1'b1;
                                cmd_done        <= 1'b1;
                                state           <= S_RESP;
                            end
                            default: begin
                                probe_hold <= probe_vec;
                                state      <= S_PROBE;
                            end
                        endcase
                    end
                end
                S_PROBE: begin
                    tlbp_index <= {~|probe_hold, {(31 - TLB_IDXBITS){1'b0}}, first_hit(probe_hold)};
                    tlbp       <= 1'b1;
                    cmd_done   <= 1'b1;
                    state      <= S_RESP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign unused_bits = ^{index[31:TLB_IDXBITS], random[31:TLB_IDXBITS],
                           entrylo0[31:LO_PFN_MSB+1], entrylo1[31:LO_PFN_MSB+1],
                           entryhi[HI_VPN2_LSB-1:HI_ASID_MSB+1]};

endmodule

// File: doc/tlb_unit.md
Name: tlb_unit

Overview:
- 32-entry, fully associative, MIPS32-style joint TLB.
- Sits beside the CP0 register file:
  - Consumes Index, Random, EntryLo0/1, PageMask and EntryHi from CP0.
  - Executes TLBR/TLBWI/TLBWR/TLBP commands from the commit stage.
  - Returns read/probe results and strobes to CP0.
- Also serves two translation ports (fetch, data) with registered, 1-cycle results.

Parameters:
- TLB_ENTRIES, 32, number of entries (power of 2).
- TLB_IDXBITS, 5, log2(TLB_ENTRIES).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- cmd_valid  in  1  TLB instruction request from commit
- cmd_op  in  2  0=TLBR 1=TLBWI 2=TLBWR 3=TLBP
- cmd_ready  out  1  command accepted this cycle
- cmd_done  out  1  command finished, 1-cycle pulse
- index  in  32  CP0 Index
- random  in  32  CP0 Random
- entrylo0  in  32  CP0 EntryLo0
- entrylo1  in  32  CP0 EntryLo1
- mask  in  12  CP0 PageMask.Mask
- entryhi  in  32  CP0 EntryHi; also supplies the current ASID
- tlbr  out  1  pulse: load tlbr_* into CP0
- tlbr_lo0  out  32  read-back EntryLo0
- tlbr_lo1  out  32  read-back EntryLo1
- tlbr_hi  out  32  read-back EntryHi
- tlbr_mask  out  12  read-back mask
- tlbwr  out  1  pulse: TLBWR executed (advances CP0 Random)
- tlbp  out  1  pulse: load tlbp_index into CP0
- tlbp_index  out  32  probe result; bit31=P, [4:0]=index
- i_req  in  1  fetch lookup valid
- i_vaddr  in  32  fetch VA
- i_hit  out  1  VA matched an entry
- i_v  out  1  matched page valid
- i_d  out  1  matched page dirty
- i_c  out  3  matched page cacheability
- i_paddr  out  32  translated PA
- d_req  in  1  data lookup valid
- d_vaddr  in  32  data VA
- d_hit  out  1  VA matched an entry
- d_v  out  1  matched page valid
- d_d  out  1  matched page dirty
- d_c  out  3  matched page cacheability
- d_paddr  out  32  translated PA

Behaviour:
- Entry storage:
  - present bit, VPN2[18:0], ASID[7:0], G, mask[11:0].
  - Per page half: PFN[19:0], C[2:0], D, V.
  - Stored G = entrylo0.G AND entrylo1.G.
  - Reset clears all present bits; no other storage is reset.
- Match condition:
  - present, and (VPN2 & ~{7'b0,mask}) == (VA[31:13] & ~{7'b0,mask}), and (G or ASID==entryhi[7:0]).
  - Multiple hits: lowest index wins.
- Odd/even select: VA bit (12 + popcount(mask)). Mask values are contiguous ones from the LSB.
- PA = {PFN,12'b0} with PA bits [12+k-1:12] replaced by VA bits for the k masked bits; PA[11:0]=VA[11:0].
- Lookup ports:
  - Result is registered; visible the cycle after req.
  - Outputs hold while req=0.
  - Reset: all lookup outputs 0.
  - Miss: hit=0, v/d/c/paddr=0.
- Command FSM, states IDLE, PROBE, RESP:
  - cmd_ready=1 only in IDLE.
  - TLBWI: writes entry index[4:0] on accept; present<=1; cmd_done the next cycle (RESP).
  - TLBWR: same, using random[4:0]; tlbwr=1 in the accept cycle.
  - TLBR: reads entry index[4:0] on accept; RESP cycle asserts tlbr=1 and cmd_done=1 with tlbr_* valid.
    - tlbr_lo{0,1} G field = stored G.
    - tlbr_hi = {VPN2,5'b0,ASID}.
    - Reading a non-present entry returns all zeros.
  - TLBP: compares entryhi in IDLE→PROBE and registers the hit vector; PROBE encodes it. RESP asserts tlbp=1, cmd_done=1, tlbp_index={~hit,26'b0,idx}; miss gives 32'h80000000.
- Simultaneous events:
  - A lookup in the same cycle as a write to the matching entry sees old contents.
  - The next cycle's lookup sees new contents.
- Reset mid-command: FSM returns to IDLE; no strobe is emitted.
- All output strobes reset to 0.

Decomposition:
- Shared package: TLB_ENTRIES, TLB_IDXBITS, cmd_op encodings, EntryLo/EntryHi field ranges.
- Sub-module tlb_match (combinational): VA + ASID against all entries → hit vector, encoded index, odd-select.
  - Instantiated three times: fetch, data, probe.

Test Plan:
- Reset, then i_req VA=0x00400000 → i_hit=0 next cycle; cmd TLBP → tlbp_index=0x80000000.
- EntryHi=0x00400005, Lo0=PFN 0x123 V=1 D=1 C=3, index=7, TLBWI; then d_req VA=0x00400abc, ASID 5 → d_hit=1, d_paddr=0x00123abc, d_c=3.
- Same entry, ASID changed to 6, G=0 → d_hit=0; rewrite with G=1 in both Lo → hit regardless of ASID.
- mask=0x003 (16K), VA=0x00404010 selects the odd half → PA uses Lo1 PFN, with PA[13:12]=VA[13:12].
- TLBWR with random=20 → tlbwr pulse in accept cycle; TLBR index=20 → tlbr pulse, tlbr_hi matches written EntryHi; entries 7 and 20 with the same VPN2 → TLBP returns 7.
- Write entry 7 and lookup its VA in the same cycle → old result; next cycle → new PFN.
